ys_poly_small_diff3: RTL and testbench

Upstream feeder for the mode-3 poly_small stage. It streams a 701-coefficient polynomial out of ram1 and produces, per packed word, the lane differences g[i-1] - g[i] (mod 2^13). Its output words and the first-word flag f_ctr go straight into the ×3 datapath. The block owns the ram1 read addressing, the cross-word carry of g[2k-1], output backpressure and the start/done control for mode 3.

---
 rtl/ys_poly_small_diff3_pkg.sv | 28 ++
 rtl/ys_poly_small_skid2.sv | 60 ++++++
 rtl/ys_poly_small_diff3.sv | 155 +++++++++++++++
 tb/tb_ys_poly_small_diff3.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ys_poly_small_diff3_pkg.sv
// Shared constants, FSM encoding and lane arithmetic for the mode-3 poly_small
// difference feeder.
package ys_poly_small_diff3_pkg;

    localparam int NTRU_N = 701;
    localparam int DW_13  = 13;
    localparam int DW_PH  = 26;
    localparam int NW     = (NTRU_N + 1) / 2;
    localparam int AW     = 9;
    localparam int SKW    = DW_PH + AW + 1;

    localparam logic [1:0]    MODE_3    = 2'd3;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NW - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Wrapping 13-bit difference a - b.
    function automatic logic [DW_13-1:0] sub13(input logic [DW_13-1:0] a,
                                               input logic [DW_13-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/ys_poly_small_skid2.sv
// Generic two-slot valid/ready buffer: an output register backed by one skid
// entry. The producer must respect the occupancy reported on count.
module ys_poly_small_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    input  logic         out_rdy,
    output logic [1:0]   count
);

    logic         out_vld_r;
    logic         skid_vld_r;
    logic [W-1:0] out_data_r;
    logic [W-1:0] skid_data_r;
    logic         pop_s;

    assign pop_s = out_vld_r && out_rdy;

    // Slot update: the skid entry drains into the output register first so
    // words leave in arrival order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_r   <= 1'b0;
            skid_vld_r  <= 1'b0;
            out_data_r  <= '0;
            skid_data_r <= '0;
        end else if (clr) begin
            out_vld_r  <= 1'b0;
            skid_vld_r <= 1'b0;
        end else if (!out_vld_r || pop_s) begin
            if (skid_vld_r) begin
                out_data_r <= skid_data_r;
                out_vld_r  <= 1'b1;
                skid_vld_r <= in_vld;
                if (in_vld) begin
                    skid_data_r <= in_data;
                end
            end else begin
                out_vld_r <= in_vld;
                if (in_vld) begin
                    out_data_r <= in_data;
                end
            end
        end else if (in_vld) begin
            skid_vld_r  <= 1'b1;
            skid_data_r <= in_data;
        end
    end

    assign out_vld  = out_vld_r;
    assign out_data = out_data_r;
    assign count    = {1'b0, out_vld_r} + {1'b0, skid_vld_r};

endmodule

// File: rtl/ys_poly_small_diff3.sv
// Mode-3 poly_small feeder: streams ram1 words and emits per-lane coefficient
// differences g[i-1] - g[i] (mod 2^13) through a 2-slot credit-managed buffer.
module ys_poly_small_diff3
    import ys_poly_small_diff3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ram1_ena,
    output logic [AW-1:0]    ram1_addra,
    input  logic [DW_PH-1:0] ram1_douta,
    output logic [DW_PH-1:0] diff_out,
    output logic [AW-1:0]    diff_addr,
    output logic             f_ctr,
    output logic             diff_vld,
    input  logic             diff_rdy,
    output logic             busy,
    output logic             done
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [AW-1:0]      addr_r;
    logic [AW-1:0]      rd_addr_r;
    logic               inflight_r;
    logic [DW_13-1:0]   prev_r;
    logic               busy_r;
    logic               done_r;

    logic               clr_s;
    logic               xfer_s;
    logic               issue_s;
    logic [1:0]         occ_s;
    logic [2:0]         load_s;
    logic [DW_13-1:0]   lane0_s;
    logic [DW_13-1:0]   lane1_s;
    logic [SKW-1:0]     push_data_s;
    logic [SKW-1:0]     out_data_s;
    logic               out_vld_s;

    assign clr_s  = (state_r == ST_IDLE) && start;
    assign xfer_s = out_vld_s && diff_rdy;

    // A slot freed by this cycle's transfer is already available to a new read.
    assign load_s  = {1'b0, occ_s} - {2'b00, xfer_s} + {2'b00, inflight_r};
    assign issue_s = (state_r == ST_RUN) && (load_s < 3'd2);

    // Lane differences for the word returning from ram1 this cycle.
    always_comb begin
        lane0_s = sub13(prev_r, ram1_douta[DW_13-1:0]);
        if (rd_addr_r == LAST_ADDR) begin
            lane1_s = 13'd0;
        end else begin
            lane1_s = sub13(ram1_douta[DW_13-1:0], ram1_douta[DW_PH-1:DW_13]);
        end
        push_data_s = {(rd_addr_r == {AW{1'b0}}), rd_addr_r, lane1_s, lane0_s};
    end

    // Next-state logic for the mode-3 control sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && (addr_r == LAST_ADDR)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && (diff_addr == LAST_ADDR)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus the registered busy/done status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Read address counter and the single-cycle in-flight tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= '0;
            rd_addr_r  <= '0;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (clr_s || (state_r == ST_DONE)) begin
                addr_r <= '0;
            end else if (issue_s) begin
                addr_r    <= addr_r + 9'd1;
                rd_addr_r <= addr_r;
            end
        end
    end

    // prev carries g[2k-1] into the next word; it follows RAM returns only.
    always_ff @(posedge clk) begin
        if (rst || clr_s) begin
            prev_r <= '0;
        end else if (inflight_r) begin
            prev_r <= ram1_douta[DW_PH-1:DW_13];
        end
    end

    ys_poly_small_skid2 #(
        .W (SKW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .in_vld   (inflight_r),
        .in_data  (push_data_s),
        .out_vld  (out_vld_s),
        .out_data (out_data_s),
        .out_rdy  (diff_rdy),
        .count    (occ_s)
    );

    assign ram1_ena   = issue_s;
    assign ram1_addra = addr_r;
    assign diff_out   = out_data_s[DW_PH-1:0];
    assign diff_addr  = out_data_s[DW_PH+AW-1:DW_PH];
    assign f_ctr      = out_vld_s && out_data_s[SKW-1];
    assign diff_vld   = out_vld_s;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_ys_poly_small_diff3.sv
// Randomized bench for ys_poly_small_diff3 with a coefficient-level reference
// model, per-cycle output checks and a ram1 behavioural memory.
module tb_ys_poly_small_diff3;
    import ys_poly_small_diff3_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             ram1_ena;
    logic [AW-1:0]    ram1_addra;
    logic [DW_PH-1:0] ram1_douta;
    logic [DW_PH-1:0] diff_out;
    logic [AW-1:0]    diff_addr;
    logic             f_ctr;
    logic             diff_vld;
    logic             diff_rdy;
    logic             busy;
    logic             done;

    ys_poly_small_diff3 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ram1_ena   (ram1_ena),
        .ram1_addra (ram1_addra),
        .ram1_douta (ram1_douta),
        .diff_out   (diff_out),
        .diff_addr  (diff_addr),
        .f_ctr      (f_ctr),
        .diff_vld   (diff_vld),
        .diff_rdy   (diff_rdy),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [DW_PH-1:0] mem [NW];
    always @(posedge clk) begin
        if (ram1_ena) ram1_douta <= mem[ram1_addra];
    end

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int p_start = 0;
    bit tcheck = 1'b0;
    int rdy_mode = 0;
    int exp_idx = 0;
    int cnt = 0;
    int xfers = 0;
    int dones = 0;
    int reads = 0;
    bit stall = 1'b0;
    logic [DW_PH-1:0] last_out;
    logic [AW-1:0]    last_addr;
    logic             last_f;
    logic [DW_PH-1:0] exp_w [NW];
    logic [DW_PH-1:0] got [NW];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Differences are defined per coefficient: d[i] = g[i-1] - g[i], g[-1]=0,
    // and the padding coefficient 701 yields 0.
    task automatic build_model();
        int g [NW*2];
        logic [12:0] d;
        for (int k = 0; k < NW; k++) begin
            g[2*k]   = int'(mem[k][12:0]);
            g[2*k+1] = int'(mem[k][25:13]);
        end
        for (int i = 0; i < NW*2; i++) begin
            if (i == NTRU_N) d = 13'd0;
            else d = 13'((i == 0 ? 0 : g[i-1]) - g[i]);
            exp_w[i/2][13*(i%2) +: 13] = d;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < NW; k++) mem[k] = 26'($urandom);
        build_model();
    endtask

    task automatic monitor();
        bit xfer;
        if (rst) begin
            exp_idx = 0; cnt = 0; stall = 1'b0;
            return;
        end
        xfer = diff_vld && diff_rdy;
        if (tcheck && cyc == p_start) begin
            chk("t1_busy", busy, 1);
            chk("t1_ena", ram1_ena, 1);
            chk("t1_addr", ram1_addra, 0);
            chk("t1_vld", diff_vld, 0);
        end
        if (stall) begin
            chk("stall_vld", diff_vld, 1);
            chk("stall_data", diff_out, last_out);
            chk("stall_addr", diff_addr, last_addr);
            chk("stall_f", f_ctr, last_f);
        end
        cnt = cnt + (ram1_ena ? 1 : 0) - (xfer ? 1 : 0);
        if (ram1_ena) begin
            reads++;
            chk("credit", cnt <= 2, 1);
        end
        if (xfer) begin
            if (exp_idx < NW) begin
                chk("word_data", diff_out, exp_w[exp_idx]);
                chk("word_addr", diff_addr, exp_idx);
                chk("word_f_ctr", f_ctr, exp_idx == 0);
                got[exp_idx] = diff_out;
                if (tcheck && exp_idx == 0) chk("first_word_cycle", cyc, p_start + 2);
                if (tcheck && exp_idx == NW - 1) chk("last_word_cycle", cyc, p_start + NW + 1);
            end else begin
                chk("extra_word", 1, 0);
            end
            exp_idx++;
            xfers++;
        end
        stall = diff_vld && !diff_rdy;
        last_out = diff_out; last_addr = diff_addr; last_f = f_ctr;
        if (done) begin
            dones++;
            chk("done_busy", busy, 0);
            chk("done_words", exp_idx, NW);
            if (tcheck) chk("done_cycle", cyc, p_start + NW + 2);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        case (rdy_mode)
            0: diff_rdy = 1'b1;
            1: diff_rdy = 1'b0;
            default: diff_rdy = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        monitor();
    endtask

    task automatic do_start();
        exp_idx = 0; cnt = 0; stall = 1'b0;
        p_start = cyc + 1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int d0 = dones;
        int n = 0;
        while (dones == d0 && n < bound) begin
            step();
            n++;
        end
        chk("done_timeout", dones != d0, 1);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_ena"}, ram1_ena, 0);
        chk({nm, "_addra"}, ram1_addra, 0);
        chk({nm, "_diff_out"}, diff_out, 0);
        chk({nm, "_diff_addr"}, diff_addr, 0);
        chk({nm, "_vld"}, diff_vld, 0);
        chk({nm, "_f_ctr"}, f_ctr, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
    endtask

    task automatic run_full();
        int x0 = xfers;
        int d0 = dones;
        do_start();
        wait_done(3000);
        repeat (3) step();
        chk("run_transfers", xfers - x0, NW);
        chk("run_dones", dones - d0, 1);
    endtask

    initial begin
        int x0, d0, r0;
        rst = 1'b1; start = 1'b0; diff_rdy = 1'b1; rdy_mode = 0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // g[i] = i with diff_rdy high, including exact timing.
        for (int k = 0; k < NW; k++) mem[k] = {13'(2*k+1), 13'(2*k)};
        build_model();
        tcheck = 1'b1;
        run_full();
        tcheck = 1'b0;
        chk("ramp_w0", got[0], 26'h3FFE000);
        chk("ramp_w1", got[1], 26'h3FFFFFF);
        chk("ramp_w349", got[349], 26'h3FFFFFF);
        chk("ramp_w350", got[350], 26'h0001FFF);

        // Sparse polynomial g[0]=5, g[1]=2.
        for (int k = 0; k < NW; k++) mem[k] = 26'd0;
        mem[0] = {13'd2, 13'd5};
        build_model();
        run_full();
        chk("sparse_w0", got[0], {13'h0003, 13'h1FFB});
        chk("sparse_w1_lane0", got[1][12:0], 13'h0002);

        // Random data with random backpressure.
        fill_random();
        rdy_mode = 2;
        run_full();

        // Long stall right after start.
        fill_random();
        rdy_mode = 1;
        r0 = reads; x0 = xfers; d0 = dones;
        do_start();
        repeat (19) step();
        chk("stall_reads", reads - r0, 2);
        rdy_mode = 0;
        wait_done(3000);
        chk("stall_transfers", xfers - x0, NW);
        chk("stall_dones", dones - d0, 1);

        // Second start while busy is ignored.
        fill_random();
        rdy_mode = 2;
        x0 = xfers; d0 = dones;
        do_start();
        repeat (4) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(3000);
        repeat (5) step();
        chk("restart_transfers", xfers - x0, NW);
        chk("restart_dones", dones - d0, 1);

        // Reset in the middle of a run, then a fresh run.
        fill_random();
        rdy_mode = 2;
        do_start();
        repeat (98) step();
        rst = 1'b1;
        step();
        check_idle_outputs("midrst");
        rst = 1'b0;
        step();
        fill_random();
        run_full();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
